// File: rtl/fetch_queue.sv
// fetch_queue
//   Instruction buffer between the 64-bit instruction-memory fetch port and the
//   two decoders of a dual-issue front end. Fetch packets of one or two
//   instructions are packed into a circular buffer. The two oldest entries are
//   presented to decode slots 0 and 1, and 0-2 entries retire per cycle.
//   A redirect (flush_i) empties the queue.
//
// Ports
//   clk_i, rst_n_i        clock (rising edge), asynchronous active-low reset
//   fetch_valid_i         fetch packet present
//   fetch_pc_i            PC of packet slot 0 (8-byte aligned)
//   fetch_data_i          {instr1, instr0}
//   fetch_mask_i          per-slot valid (bit0 = instr0, bit1 = instr1)
//   fetch_ready_o         at least two free entries
//   flush_i               discard all contents
//   deq_count_i           entries consumed by decode this cycle (0..2)
//   instr0_o/pc0_o/valid0_o   oldest entry
//   instr1_o/pc1_o/valid1_o   second-oldest entry
//   count_o               current occupancy
module fetch_queue #(
  parameter int unsigned DEPTH = 8
) (
  input  logic                     clk_i,
  input  logic                     rst_n_i,
  input  logic                     fetch_valid_i,
  input  logic [31:0]              fetch_pc_i,
  input  logic [63:0]              fetch_data_i,
  input  logic [1:0]               fetch_mask_i,
  output logic                     fetch_ready_o,
  input  logic                     flush_i,
  input  logic [1:0]               deq_count_i,
  output logic [31:0]              instr0_o,
  output logic [31:0]              pc0_o,
  output logic                     valid0_o,
  output logic [31:0]              instr1_o,
  output logic [31:0]              pc1_o,
  output logic                     valid1_o,
  output logic [$clog2(DEPTH):0]   count_o
);

  localparam int unsigned PW = $clog2(DEPTH);
  localparam int unsigned CW = PW + 1;

  // addi x0,x0,0 -- what an empty decode slot sees
  localparam logic [31:0]   NOP_INSTR = 32'h0000_0013;
  localparam logic [CW-1:0] READY_MAX = CW'(DEPTH - 2);

  // Storage is deliberately left without reset; occupancy alone defines validity.
  logic [31:0]   r_instr [DEPTH];
  logic [31:0]   r_pc    [DEPTH];

  logic [PW-1:0] r_head;
  logic [PW-1:0] r_tail;
  logic [CW-1:0] r_count;

  logic          w_accept;
  logic [1:0]    w_enq;
  logic          w_wr0;
  logic          w_wr1;
  logic [31:0]   w_wdata0;
  logic [31:0]   w_wpc0;
  logic [PW-1:0] w_tail1;
  logic [PW-1:0] w_head1;
  logic [CW-1:0] w_deq_req;
  logic [CW-1:0] w_deq;

  // Ready depends on registered occupancy only, never on this cycle's dequeue.
  assign fetch_ready_o = (r_count <= READY_MAX);
  assign count_o       = r_count;

  assign w_tail1 = r_tail + PW'(1);
  assign w_head1 = r_head + PW'(1);

  // Enqueue packing: a lone upper-slot instruction lands in the first free
  // entry with its own PC (pc+4), so the queue never holds holes.
  always_comb begin
    w_accept = fetch_valid_i & fetch_ready_o & ~flush_i;
    w_enq    = 2'd0;
    w_wr0    = 1'b0;
    w_wr1    = 1'b0;
    w_wdata0 = fetch_data_i[31:0];
    w_wpc0   = fetch_pc_i;
    if (w_accept) begin
      case (fetch_mask_i)
        2'b01: begin
          w_wr0 = 1'b1;
          w_enq = 2'd1;
        end
        2'b10: begin
          w_wr0    = 1'b1;
          w_enq    = 2'd1;
          w_wdata0 = fetch_data_i[63:32];
          w_wpc0   = fetch_pc_i + 32'd4;
        end
        2'b11: begin
          w_wr0 = 1'b1;
          w_wr1 = 1'b1;
          w_enq = 2'd2;
        end
        default: begin
          w_enq = 2'd0;
        end
      endcase
    end
  end

  // Over-dequeue is illegal; clamp so occupancy can never underflow.
  always_comb begin
    w_deq_req = CW'(deq_count_i);
    w_deq     = (w_deq_req > r_count) ? r_count : w_deq_req;
  end

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      r_head  <= '0;
      r_tail  <= '0;
      r_count <= '0;
    end else if (flush_i) begin
      r_head  <= '0;
      r_tail  <= '0;
      r_count <= '0;
    end else begin
      r_head  <= r_head + PW'(w_deq);
      r_tail  <= r_tail + PW'(w_enq);
      r_count <= r_count + CW'(w_enq) - w_deq;
    end
  end

  // Second entry of a full packet goes to tail+1, which may wrap to entry 0.
  always_ff @(posedge clk_i) begin
    if (w_wr0) begin
      r_instr[r_tail] <= w_wdata0;
      r_pc[r_tail]    <= w_wpc0;
    end
    if (w_wr1) begin
      r_instr[w_tail1] <= fetch_data_i[63:32];
      r_pc[w_tail1]    <= fetch_pc_i + 32'd4;
    end
  end

  always_comb begin
    valid0_o = (r_count != '0);
    valid1_o = (r_count >= CW'(2));
    instr0_o = valid0_o ? r_instr[r_head]  : NOP_INSTR;
    pc0_o    = valid0_o ? r_pc[r_head]     : '0;
    instr1_o = valid1_o ? r_instr[w_head1] : NOP_INSTR;
    pc1_o    = valid1_o ? r_pc[w_head1]    : '0;
  end

  always_ff @(posedge clk_i) begin
    if (rst_n_i && !flush_i) begin
      assert (w_deq_req <= r_count);
      assert (deq_count_i != 2'd3);
    end
  end

endmodule

// File: tb/tb_fetch_queue.sv
`timescale 1ns/1ps
module tb_fetch_queue;

  localparam int unsigned DEPTH = 8;
  localparam int unsigned CW    = $clog2(DEPTH) + 1;
  localparam logic [31:0] NOP   = 32'h0000_0013;

  logic          clk_i = 1'b0;
  logic          rst_n_i;
  logic          fetch_valid_i;
  logic [31:0]   fetch_pc_i;
  logic [63:0]   fetch_data_i;
  logic [1:0]    fetch_mask_i;
  logic          fetch_ready_o;
  logic          flush_i;
  logic [1:0]    deq_count_i;
  logic [31:0]   instr0_o, pc0_o, instr1_o, pc1_o;
  logic          valid0_o, valid1_o;
  logic [CW-1:0] count_o;

  fetch_queue #(.DEPTH(DEPTH)) dut (
    .clk_i         (clk_i),
    .rst_n_i       (rst_n_i),
    .fetch_valid_i (fetch_valid_i),
    .fetch_pc_i    (fetch_pc_i),
    .fetch_data_i  (fetch_data_i),
    .fetch_mask_i  (fetch_mask_i),
    .fetch_ready_o (fetch_ready_o),
    .flush_i       (flush_i),
    .deq_count_i   (deq_count_i),
    .instr0_o      (instr0_o),
    .pc0_o         (pc0_o),
    .valid0_o      (valid0_o),
    .instr1_o      (instr1_o),
    .pc1_o         (pc1_o),
    .valid1_o      (valid1_o),
    .count_o       (count_o)
  );

  always #5 clk_i = ~clk_i;

  typedef struct {
    logic [31:0] instr;
    logic [31:0] pc;
  } ent_t;

  ent_t mq[$];
  int   n_total = 0;
  int   n_bad   = 0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_total++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got=%0h expected=%0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  function automatic logic [63:0] mk(input logic [31:0] pc);
    return {32'hB000_0000 + pc + 32'd4, 32'hA000_0000 + pc};
  endfunction

  task automatic compare_all();
    int sz;
    sz = mq.size();
    check("count",  64'(count_o),       64'(sz));
    check("ready",  64'(fetch_ready_o), 64'((DEPTH - sz) >= 2));
    check("valid0", 64'(valid0_o),      64'(sz >= 1));
    check("valid1", 64'(valid1_o),      64'(sz >= 2));
    check("instr0", 64'(instr0_o),      64'(sz >= 1 ? mq[0].instr : NOP));
    check("pc0",    64'(pc0_o),         64'(sz >= 1 ? mq[0].pc : 32'd0));
    check("instr1", 64'(instr1_o),      64'(sz >= 2 ? mq[1].instr : NOP));
    check("pc1",    64'(pc1_o),         64'(sz >= 2 ? mq[1].pc : 32'd0));
  endtask

  // Drive one cycle of stimulus, advance the reference queue at the edge,
  // then compare every output shortly after the edge.
  task automatic step(input logic fv, input logic [31:0] pc, input logic [63:0] data,
                      input logic [1:0] mask, input logic [1:0] deq, input logic fl);
    bit acc;
    int d;
    fetch_valid_i = fv;
    fetch_pc_i    = pc;
    fetch_data_i  = data;
    fetch_mask_i  = mask;
    deq_count_i   = deq;
    flush_i       = fl;
    @(posedge clk_i);
    acc = fv && ((DEPTH - mq.size()) >= 2);
    if (fl) begin
      mq.delete();
    end else begin
      d = (int'(deq) > mq.size()) ? mq.size() : int'(deq);
      repeat (d) void'(mq.pop_front());
      if (acc) begin
        if (mask[0]) mq.push_back('{instr: data[31:0],  pc: pc});
        if (mask[1]) mq.push_back('{instr: data[63:32], pc: pc + 32'd4});
      end
    end
    #1;
    compare_all();
  endtask

  task automatic idle(input logic [1:0] deq);
    step(1'b0, 32'd0, 64'd0, 2'b00, deq, 1'b0);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    logic [31:0] p;
    logic [31:0] rpc;
    logic [63:0] rdata;
    logic [1:0]  rdeq;
    int          mx;

    rst_n_i       = 1'b0;
    fetch_valid_i = 1'b0;
    fetch_pc_i    = '0;
    fetch_data_i  = '0;
    fetch_mask_i  = 2'b00;
    flush_i       = 1'b0;
    deq_count_i   = 2'd0;
    #12;
    rst_n_i = 1'b1;
    #1;
    compare_all();
    check("rst_count", 64'(count_o), 64'd0);
    check("rst_ready", 64'(fetch_ready_o), 64'd1);

    // Two-instruction packet
    step(1'b1, 32'h100, {32'h0020_8093, 32'h0010_0093}, 2'b11, 2'd0, 1'b0);
    check("t1_instr0", 64'(instr0_o), 64'h0010_0093);
    check("t1_pc0",    64'(pc0_o),    64'h100);
    check("t1_instr1", 64'(instr1_o), 64'h0020_8093);
    check("t1_pc1",    64'(pc1_o),    64'h104);
    check("t1_count",  64'(count_o),  64'd2);

    // Upper-slot-only packet while both old entries retire
    step(1'b1, 32'h200, {32'h0030_0113, 32'hDEAD_0000}, 2'b10, 2'd2, 1'b0);
    check("t2_instr0", 64'(instr0_o), 64'h0030_0113);
    check("t2_pc0",    64'(pc0_o),    64'h204);
    check("t2_valid1", 64'(valid1_o), 64'd0);
    check("t2_instr1", 64'(instr1_o), 64'h13);
    check("t2_count",  64'(count_o),  64'd1);

    // Move pointers to entry 6 so the fill straddles the wrap
    step(1'b0, 32'd0, 64'd0, 2'b00, 2'd0, 1'b1);
    p = 32'h1000;
    step(1'b1, p, mk(p), 2'b01, 2'd0, 1'b0);
    for (int i = 0; i < 5; i++) begin
      p += 32'd8;
      step(1'b1, p, mk(p), 2'b01, 2'd1, 1'b0);
    end
    idle(2'd1);
    p += 32'd8;
    step(1'b1, p, mk(p), 2'b01, 2'd0, 1'b0);
    for (int i = 0; i < 3; i++) begin
      p += 32'd8;
      step(1'b1, p, mk(p), 2'b11, 2'd0, 1'b0);
    end
    check("t3_full_count", 64'(count_o), 64'd7);
    check("t3_full_ready", 64'(fetch_ready_o), 64'd0);
    p += 32'd8;
    step(1'b1, p, mk(p), 2'b11, 2'd0, 1'b0);
    check("t3_held_count", 64'(count_o), 64'd7);
    idle(2'd2);
    idle(2'd2);
    idle(2'd2);
    idle(2'd1);
    check("t3_drain", 64'(count_o), 64'd0);

    // Simultaneous enqueue and dequeue
    p = 32'h3000;
    step(1'b1, p, mk(p), 2'b11, 2'd0, 1'b0);
    step(1'b1, p + 32'd8, mk(p + 32'd8), 2'b11, 2'd0, 1'b0);
    step(1'b1, p + 32'd16, mk(p + 32'd16), 2'b11, 2'd1, 1'b0);
    rdata = mk(p);
    check("t4_count",  64'(count_o),  64'd5);
    check("t4_pc0",    64'(pc0_o),    64'(p + 32'd4));
    check("t4_instr0", 64'(instr0_o), 64'(rdata[63:32]));

    // Flush beats a same-cycle enqueue and dequeue
    step(1'b1, 32'h4000, mk(32'h4000), 2'b01, 2'd0, 1'b0);
    check("t5_pre", 64'(count_o), 64'd6);
    step(1'b1, 32'h5000, mk(32'h5000), 2'b11, 2'd2, 1'b1);
    check("t5_count",  64'(count_o),       64'd0);
    check("t5_valid0", 64'(valid0_o),      64'd0);
    check("t5_ready",  64'(fetch_ready_o), 64'd1);

    // Asynchronous reset between edges
    step(1'b1, 32'h6000, mk(32'h6000), 2'b11, 2'd0, 1'b0);
    step(1'b1, 32'h6008, mk(32'h6008), 2'b01, 2'd0, 1'b0);
    check("t6_pre", 64'(count_o), 64'd3);
    #2;
    rst_n_i = 1'b0;
    #1;
    mq.delete();
    check("t6_count",  64'(count_o),  64'd0);
    check("t6_valid0", 64'(valid0_o), 64'd0);
    check("t6_valid1", 64'(valid1_o), 64'd0);
    check("t6_instr0", 64'(instr0_o), 64'h13);
    check("t6_ready",  64'(fetch_ready_o), 64'd1);
    #1;
    rst_n_i = 1'b1;

    // Randomized traffic against the reference queue
    for (int i = 0; i < 3000; i++) begin
      rpc   = $urandom() & 32'hFFFF_FFF8;
      rdata = {$urandom(), $urandom()};
      mx    = (mq.size() < 2) ? mq.size() : 2;
      rdeq  = 2'($urandom_range(0, mx));
      step(($urandom_range(0, 3) != 0), rpc, rdata, 2'($urandom_range(0, 3)),
           rdeq, ($urandom_range(0, 49) == 0));
    end

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule
